prod_signature_checker: RTL
===========================

// Module: prod_signature_checker
// PURPOSE
//  Downstream of the product output path: snoops the write stream (we/addr/data) going into the
//  C result RAM and compresses it into a MISR signature with a word count and address-sequence check.
//  Lets the TCU read pass/fail from one register instead of draining the result RAM over Avalon.
//  One instance per phase (pos/neg), each on that phase's divided clock.
// PARAMETERS
//  DATA_WIDTH  30            product word width (BITS_OUT of the multiplier under test)
//  ADDR_WIDTH  11            result RAM address width
//  SIG_WIDTH   32            signature register width
//  POLY        32'h04C11DB7  MISR feedback polynomial (low SIG_WIDTH bits used)
//  SEED        32'hFFFFFFFF  signature value loaded on start
// PORTS
//  pll_clock       in   1             the single clock; all state updates on rising edge
//  reset           in   1             synchronous, active-high
//  start           in   1             1-cycle pulse: clear and arm the checker
//  expected_count  in   ADDR_WIDTH+1  number of words in the run (sampled on start)
//  we_in           in   1             write enable of the result-RAM write port (word accepted when 1)
//  addr_in         in   ADDR_WIDTH    write address
//  data_in         in   DATA_WIDTH    product word
//  busy            out  1             1 in ARMED or RUN
//  done            out  1             1 in DONE
//  signature       out  SIG_WIDTH     running/final MISR value
//  word_count      out  ADDR_WIDTH+1  words accepted since start
//  seq_err         out  1             sticky: address not previous+1 (mod 2^ADDR_WIDTH)
//  first_bad_addr  out  ADDR_WIDTH    addr_in of first sequence violation
//  timeout         out  1             sticky watchdog flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE; signature=0, word_count=0, seq_err=0, first_bad_addr=0, timeout=0, busy=0, done=0.
//  - FSM IDLE -start-> ARMED (or DONE if expected_count==0) ; ARMED -we_in-> RUN ;
//    RUN -last word accepted-> DONE ; DONE -start-> ARMED. we_in ignored in IDLE and DONE.
//  - On start (any state): signature<=SEED, word_count<=0, seq_err<=0, first_bad_addr<=0,
//    timeout<=0, latch expected_count. start has priority over a same-cycle we_in (word dropped).
//  - Accept (ARMED/RUN, we_in=1): word_count+1; signature<=MISR(signature, fold(data_in));
//    MISR(s,d) = ({s[SIG_WIDTH-2:0],1'b0} ^ (s[SIG_WIDTH-1] ? POLY : 0)) ^ d.
//    fold(): zero-extend data_in to multiple of SIG_WIDTH, XOR all SIG_WIDTH chunks.
//  - Address check: first accepted word sets base (no check); each later word must equal
//    prev_addr+1 with wrap 2^ADDR_WIDTH-1 -> 0; first violation sets seq_err, captures addr_in; later ones ignored.
//  - Latency: outputs reflect an accepted word on the next rising edge; done rises the edge after
//    the word making word_count==expected_count. signature/word_count frozen in DONE until start.
//  - Reset mid-run wins over everything; returns to IDLE values above.
// CONFIGURATION
//  - Macro SIG_CHECK_TIMEOUT_EN: adds parameter TIMEOUT (default 1024) and an idle counter cleared
//    on start/accept, counting in ARMED/RUN; reaching TIMEOUT -> timeout<=1, state DONE.
//  - Without it: no counter; timeout tied 0; ARMED/RUN wait indefinitely.
// STRUCTURE
//  - Shared package mult_test_pkg: state encoding (IDLE/ARMED/RUN/DONE), default POLY/SEED constants.
//  - One sub-module: misr_step (combinational fold + MISR next-state), reused by the bench model.
//  - Top holds FSM, counters, address tracker, optional watchdog.
// TESTING
//  - Reset then idle 10 cycles, we_in toggling -> all outputs 0, state IDLE, word_count stays 0.
//  - start, expected_count=4, data 1,2,3,4 at addr 0..3 -> done 1 cycle after 4th, word_count=4,
//    seq_err=0, signature equals misr_step model from SEED.
//  - expected_count=3, addresses 2046,2047,0 -> wrap accepted, seq_err=0; repeat with 5,6,8 -> seq_err=1, first_bad_addr=8.
//  - start asserted with we_in in RUN after 2 words -> counters/sig reset to SEED/0, that word not counted.
//  - start with expected_count=0 -> done next edge, signature=SEED, word_count=0.
//  - SIG_CHECK_TIMEOUT_EN, TIMEOUT=16: start, no writes -> timeout=1, done=1 after 16 cycles; undefined build -> busy stays 1.

Source files
------------

// File: rtl/mult_test_pkg.sv
// Shared types and constants for the product-output test blocks.
// Holds the checker FSM encoding and the default MISR polynomial and seed.
package mult_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;
  localparam logic [31:0] DEFAULT_SEED = 32'hFFFFFFFF;

endpackage

// File: rtl/misr_step.sv
// Purpose: fold a product word into SIG_WIDTH bits and advance the MISR by one step.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is committed.
module misr_step #(
  parameter int          DATA_WIDTH = 30,
  parameter int          SIG_WIDTH  = 32,
  parameter logic [31:0] POLY       = 32'h04C11DB7
) (
  input  logic [SIG_WIDTH-1:0]  sig_cur,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [SIG_WIDTH-1:0]  sig_next
);

  localparam int NCHUNK = (DATA_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;

  logic [NCHUNK*SIG_WIDTH-1:0] padded;
  logic [SIG_WIDTH-1:0]        folded;

  always_comb begin
    padded                   = '0;
    padded[DATA_WIDTH-1:0]   = data;
    folded                   = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      folded = folded ^ padded[i*SIG_WIDTH +: SIG_WIDTH];
    end
    sig_next = {sig_cur[SIG_WIDTH-2:0], 1'b0}
             ^ (sig_cur[SIG_WIDTH-1] ? POLY[SIG_WIDTH-1:0] : '0)
             ^ folded;
  end

endmodule

// File: rtl/prod_signature_checker.sv
// Purpose: snoop result-RAM writes into a MISR signature, word count and address-sequence check.
// Latency: an accepted word is visible after the next rising edge; done rises on the edge taking the last word.
// Backpressure: none, passive snooper. Optional watchdog under SIG_CHECK_TIMEOUT_EN.
module prod_signature_checker
  import mult_test_pkg::*;
#(
  parameter int          DATA_WIDTH = 30,
  parameter int          ADDR_WIDTH = 11,
  parameter int          SIG_WIDTH  = 32,
  parameter logic [31:0] POLY       = DEFAULT_POLY,
  parameter logic [31:0] SEED       = DEFAULT_SEED
`ifdef SIG_CHECK_TIMEOUT_EN
  ,
  parameter int          TIMEOUT    = 1024
`endif
) (
  input  logic                  pll_clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   expected_count,
  input  logic                  we_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  busy,
  output logic                  done,
  output logic [SIG_WIDTH-1:0]  signature,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  seq_err,
  output logic [ADDR_WIDTH-1:0] first_bad_addr,
  output logic                  timeout
);

  state_t                state_q, state_d;
  logic [SIG_WIDTH-1:0]  sig_q, sig_next;
  logic [ADDR_WIDTH:0]   count_q, count_inc, exp_q;
  logic [ADDR_WIDTH-1:0] prev_addr_q, addr_inc, bad_addr_q;
  logic                  seq_err_q;
  logic                  active, accept, last_word, addr_ok, tmo_hit;

  misr_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .SIG_WIDTH  (SIG_WIDTH),
    .POLY       (POLY)
  ) u_misr_step (
    .sig_cur  (sig_q),
    .data     (data_in),
    .sig_next (sig_next)
  );

  assign active    = (state_q == ST_ARMED) || (state_q == ST_RUN);
  // start steals the cycle: a coincident write is dropped
  assign accept    = active && we_in && !start;
  assign count_inc = count_q + (ADDR_WIDTH+1)'(1);
  assign last_word = (count_inc == exp_q);
  assign addr_inc  = prev_addr_q + ADDR_WIDTH'(1);
  assign addr_ok   = (addr_in == addr_inc);

  always_ff @(posedge pll_clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = (expected_count == '0) ? ST_DONE : ST_ARMED;
    end else begin
      case (state_q)
        ST_ARMED, ST_RUN: begin
          if (accept)       state_d = last_word ? ST_DONE : ST_RUN;
          else if (tmo_hit) state_d = ST_DONE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // The first word of a run (taken in ARMED) only sets the address base
  always_ff @(posedge pll_clock) begin
    if (reset) begin
      sig_q       <= '0;
      count_q     <= '0;
      exp_q       <= '0;
      prev_addr_q <= '0;
      seq_err_q   <= 1'b0;
      bad_addr_q  <= '0;
    end else if (start) begin
      sig_q       <= SEED[SIG_WIDTH-1:0];
      count_q     <= '0;
      exp_q       <= expected_count;
      seq_err_q   <= 1'b0;
      bad_addr_q  <= '0;
    end else if (accept) begin
      sig_q       <= sig_next;
      count_q     <= count_inc;
      prev_addr_q <= addr_in;
      if ((state_q == ST_RUN) && !addr_ok && !seq_err_q) begin
        seq_err_q  <= 1'b1;
        bad_addr_q <= addr_in;
      end
    end
  end

`ifdef SIG_CHECK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] idle_q;
  logic          timeout_q;

  assign tmo_hit = active && !accept && (idle_q == TW'(TIMEOUT - 1));

  always_ff @(posedge pll_clock) begin
    if (reset || start) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else if (accept) begin
      idle_q    <= '0;
    end else if (tmo_hit) begin
      idle_q    <= '0;
      timeout_q <= 1'b1;
    end else if (active) begin
      idle_q    <= idle_q + TW'(1);
    end
  end

  assign timeout = timeout_q;
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  assign busy           = active;
  assign done           = (state_q == ST_DONE);
  assign signature      = sig_q;
  assign word_count     = count_q;
  assign seq_err        = seq_err_q;
  assign first_bad_addr = bad_addr_q;

endmodule
